// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_init_sequencer
//  Purpose  : Walks a fixed register-write table and feeds addr/sub/data plus
//             a start strobe to an I2C master, one entry per ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_init_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         N_REGS      = 4,
  parameter int         START_CYC   = 2,
  parameter int         GAP_CYC     = 16,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       ready,
  output logic [6:0] addr,
  output logic [7:0] sub,
  output logic [7:0] data,
  output logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] index
);

  // One shared counter serves the start, timeout and gap phases; it only
  // ever holds values up to (phase length - 1).
  localparam int c_cnt_max = (TIMEOUT_CYC > GAP_CYC)
                             ? ((TIMEOUT_CYC > START_CYC) ? TIMEOUT_CYC : START_CYC)
                             : ((GAP_CYC > START_CYC) ? GAP_CYC : START_CYC);
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(START_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_to_last    = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [2:0]         c_last_idx   = 3'(N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]         index_q, index_d;
  logic [7:0]         sub_q, sub_d;
  logic [7:0]         data_q, data_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               go_q;
  logic               go_rise;

  function automatic logic [15:0] rom_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_entry = 16'h20_0F;
      3'd1:    rom_entry = 16'h23_30;
      3'd2:    rom_entry = 16'h22_08;
      3'd3:    rom_entry = 16'h21_00;
      3'd4:    rom_entry = 16'h24_00;
      3'd5:    rom_entry = 16'h2E_00;
      3'd6:    rom_entry = 16'h32_00;
      default: rom_entry = 16'h33_00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    sub_d   = sub_q;
    data_d  = data_q;
    error_d = error_q;
    done_d  = 1'b0;
    go_rise = go & ~go_q;

    case (state_q)
      S_IDLE: begin
        // A go edge seen while the master is busy is dropped, not queued.
        if (go_rise && ready) begin
          state_d = S_LOAD;
          index_d = 3'd0;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        {sub_d, data_d} = rom_entry(index_q);
        cnt_d           = '0;
        state_d         = S_START;
      end
      S_START: begin
        if (cnt_q == c_start_last) begin
          cnt_d   = '0;
          state_d = S_WAIT_LO;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      S_WAIT_LO: begin
        if (!ready) begin
          state_d = S_WAIT_HI;
        end else if (cnt_q == c_to_last) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      S_WAIT_HI: begin
        if (ready) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == c_gap_last) begin
          if (index_q == c_last_idx) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 3'd1;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      index_q <= 3'd0;
      sub_q   <= 8'd0;
      data_q  <= 8'd0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      sub_q   <= sub_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      go_q    <= go;
    end
  end

  assign addr  = DEV_ADDR;
  assign sub   = sub_q;
  assign data  = data_q;
  assign start = start_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;
  assign index = index_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_init_sequencer
//  Purpose  : Directed bench with a ready-handshake master model and a queue
//             of expected (sub,data) writes checked on each start strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, go, ready, go6, ready6;
  logic [6:0] addr, addr6;
  logic [7:0] sub, data, sub6, data6;
  logic       start, busy, done, error;
  logic       start6, busy6, done6, error6;
  logic [2:0] index, index6;

  i2c_init_sequencer dut (
    .clk(clk), .reset(reset), .go(go), .ready(ready),
    .addr(addr), .sub(sub), .data(data), .start(start),
    .busy(busy), .done(done), .error(error), .index(index)
  );

  i2c_init_sequencer #(.N_REGS(1), .GAP_CYC(0)) dut6 (
    .clk(clk), .reset(reset), .go(go6), .ready(ready6),
    .addr(addr6), .sub(sub6), .data(data6), .start(start6),
    .busy(busy6), .done(done6), .error(error6), .index(index6)
  );

  // Monitor looks at whichever instance is selected
  int sel = 0;
  logic       m_start, m_busy, m_done, m_error;
  logic [7:0] m_sub, m_data;
  logic [6:0] m_addr;
  logic [2:0] m_index;
  assign m_start = (sel != 0) ? start6 : start;
  assign m_busy  = (sel != 0) ? busy6  : busy;
  assign m_done  = (sel != 0) ? done6  : done;
  assign m_error = (sel != 0) ? error6 : error;
  assign m_sub   = (sel != 0) ? sub6   : sub;
  assign m_data  = (sel != 0) ? data6  : data;
  assign m_addr  = (sel != 0) ? addr6  : addr;
  assign m_index = (sel != 0) ? index6 : index;

  typedef struct packed { logic [7:0] sub; logic [7:0] data; } exp_t;
  exp_t expq[$];

  int tests = 0, fails = 0;
  int mode = 0;            // 0 manual ready, 1 master model, 2 master never responds
  int mcnt = -1;
  int stepno = 0, start_len = 0, start_cnt = 0, done_cnt = 0;
  int done_step = 0, ready_rise_step = 0;
  logic prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ready(input logic v);
    if (sel != 0) ready6 = v;
    else          ready  = v;
  endtask

  // One clock: sample at negedge, score start strobes, advance master model.
  task automatic step();
    exp_t e;
    @(negedge clk);
    stepno++;
    if (mode == 1 && mcnt >= 0) begin
      mcnt++;
      if (mcnt == 3) set_ready(1'b0);
      if (mcnt == 23) begin
        set_ready(1'b1);
        ready_rise_step = stepno;
        mcnt = -1;
      end
    end
    if (m_start && !prev_start) begin
      start_cnt++;
      start_len = 1;
      mcnt = 0;
      if (expq.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("sub", m_sub, e.sub);
        check("data", m_data, e.data);
        check("addr", m_addr, 7'h68);
      end
    end else if (m_start) begin
      start_len++;
    end else if (prev_start) begin
      check("start_len", start_len, 2);
    end
    if (m_done) begin
      done_cnt++;
      done_step = stepno;
    end
    prev_start = m_start;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_table(input int n);
    exp_t rom [0:3];
    rom[0] = '{8'h20, 8'h0F};
    rom[1] = '{8'h23, 8'h30};
    rom[2] = '{8'h22, 8'h08};
    rom[3] = '{8'h21, 8'h00};
    for (int i = 0; i < n; i++) expq.push_back(rom[i]);
  endtask

  task automatic wait_starts(input int target, input int bound, input string tag);
    int n = 0;
    while (start_cnt < target && n < bound) begin step(); n++; end
    check(tag, 32'(start_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    do begin step(); n++; end while (m_busy && n < bound);
    check(tag, m_busy, 1'b0);
  endtask

  task automatic pulse_go();
    if (sel != 0) go6 = 1'b1; else go = 1'b1;
    step();
    if (sel != 0) go6 = 1'b0; else go = 1'b0;
  endtask

  initial begin
    int base, n;
    reset = 1'b1; go = 1'b0; ready = 1'b1; go6 = 1'b0; ready6 = 1'b1;
    steps(3);
    reset = 1'b0;
    step();
    check("rst_start", start, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_error", error, 1'b0);
    check("rst_index", index, 3'd0);
    check("rst_sub",   sub,   8'h00);
    check("rst_data",  data,  8'h00);
    check("rst_addr",  addr,  7'h68);

    // 1: full four-entry sequence with a responsive master
    mode = 1; done_cnt = 0; base = start_cnt;
    push_table(4);
    go = 1'b1;
    step();
    check("lat_busy", busy, 1'b1);
    check("lat_start0", start, 1'b0);
    step();
    check("lat_start1", start, 1'b1);
    go = 1'b0;
    wait_idle(400, "t1_idle");
    steps(5);
    check("t1_starts", start_cnt - base, 4);
    check("t1_done",   done_cnt, 1);
    check("t1_queue",  expq.size(), 0);
    check("t1_index",  index, 3'd3);
    check("t1_error",  error, 1'b0);

    // 2: master never drops ready -> timeout
    mode = 2; done_cnt = 0; base = start_cnt;
    push_table(1);
    pulse_go();
    wait_starts(base + 1, 10, "t2_start");
    n = 0;
    while (start && n < 10) begin step(); n++; end
    n = 0;
    while (!error && n < 400) begin step(); n++; end
    check("t2_timeout_cyc", n, 255);
    check("t2_error", error, 1'b1);
    check("t2_busy",  busy,  1'b0);
    steps(5);
    check("t2_done",   done_cnt, 0);
    check("t2_starts", start_cnt - base, 1);
    mode = 1;
    push_table(4);
    pulse_go();
    check("t2_err_clr", error, 1'b0);
    wait_idle(400, "t2_idle");
    check("t2_done2", done_cnt, 1);

    // 3: go held high then toggled while busy -> one sequence only
    done_cnt = 0; base = start_cnt;
    push_table(4);
    go = 1'b1;
    steps(100);
    for (int i = 0; i < 20; i++) begin go = ~go; steps(2); end
    go = 1'b0;
    wait_idle(400, "t3_idle");
    steps(60);
    check("t3_starts", start_cnt - base, 4);
    check("t3_done",   done_cnt, 1);
    check("t3_queue",  expq.size(), 0);

    // 4: reset while entry 2 waits for ready to return
    base = start_cnt;
    push_table(4);
    pulse_go();
    wait_starts(base + 3, 200, "t4_entry2");
    steps(10);
    check("t4_pre_index", index, 3'd2);
    reset = 1'b1;
    step();
    check("t4_start", start, 1'b0);
    check("t4_busy",  busy,  1'b0);
    check("t4_index", index, 3'd0);
    reset = 1'b0; mode = 0; mcnt = -1; ready = 1'b1;
    expq.delete();
    steps(30);
    check("t4_no_more", start_cnt - base, 3);
    mode = 1; done_cnt = 0;
    push_table(4);
    pulse_go();
    wait_starts(base + 4, 10, "t4_restart");
    check("t4_re_index", index, 3'd0);
    wait_idle(400, "t4_idle");
    check("t4_done", done_cnt, 1);

    // 5: go while master not ready is discarded
    mode = 0; ready = 1'b0; base = start_cnt;
    pulse_go();
    steps(10);
    check("t5_ignored_busy",  busy, 1'b0);
    check("t5_ignored_start", start_cnt - base, 0);
    ready = 1'b1;
    steps(2);
    mode = 1; done_cnt = 0;
    push_table(4);
    pulse_go();
    check("t5_accept", busy, 1'b1);
    wait_idle(400, "t5_idle");
    check("t5_done", done_cnt, 1);

    // 6: single entry, zero gap
    sel = 1; mode = 1; done_cnt = 0; base = start_cnt; prev_start = 1'b0;
    push_table(1);
    pulse_go();
    wait_idle(200, "t6_idle");
    steps(3);
    check("t6_starts", start_cnt - base, 1);
    check("t6_done",   done_cnt, 1);
    check("t6_queue",  expq.size(), 0);
    check("t6_done_lat", done_step - ready_rise_step, 2);
    check("t6_index",  index6, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
